// File: rtl/milestone_sequencer.sv
// Top-level run sequencer for the decoder: runs loader, Milestone 2, then Milestone 1,
// muxing the single SRAM port to whichever stage is active and watching each stage for a hang.
module milestone_sequencer #(
    parameter logic [23:0] TIMEOUT_CYCLES = 24'd12_000_000,
    parameter logic [2:0]  STAGE_GAP      = 3'd2
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic        Start,
    input  logic        LD_done,
    input  logic        M2_done,
    input  logic        M1_done,
    input  logic [17:0] LD_SRAM_address,
    input  logic [17:0] M2_SRAM_address,
    input  logic [17:0] M1_SRAM_address,
    input  logic [15:0] LD_SRAM_write_data,
    input  logic [15:0] M2_SRAM_write_data,
    input  logic [15:0] M1_SRAM_write_data,
    input  logic        LD_SRAM_we_n,
    input  logic        M2_SRAM_we_n,
    input  logic        M1_SRAM_we_n,
    output logic        LD_enable,
    output logic        M2_enable,
    output logic        M1_enable,
    output logic [17:0] SRAM_address,
    output logic [15:0] SRAM_write_data,
    output logic        SRAM_we_n,
    output logic [1:0]  Stage_id,
    output logic        Busy,
    output logic        Done,
    output logic        Error
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_GAP1,
        S_M2,
        S_GAP2,
        S_M1,
        S_DONE,
        S_ERROR
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic [23:0] r_watchdog;
    logic [2:0]  r_gap;
    logic        r_donePulse;
    logic        w_timeout;
    logic        w_gapExpired;
    logic        w_inStage;
    logic        w_inGap;

    assign w_timeout    = (r_watchdog == TIMEOUT_CYCLES - 24'd1);
    assign w_gapExpired = (r_gap == STAGE_GAP - 3'd1);
    assign w_inStage    = (r_state == S_LOAD) || (r_state == S_M2) || (r_state == S_M1);
    assign w_inGap      = (r_state == S_GAP1) || (r_state == S_GAP2);

    // Done wins over a timeout landing in the same cycle; with no gap the done pulse jumps straight on.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (Start) w_next = S_LOAD;
            S_LOAD: begin
                if (LD_done)        w_next = (STAGE_GAP == 3'd0) ? S_M2 : S_GAP1;
                else if (w_timeout) w_next = S_ERROR;
            end
            S_GAP1:  if (w_gapExpired) w_next = S_M2;
            S_M2: begin
                if (M2_done)        w_next = (STAGE_GAP == 3'd0) ? S_M1 : S_GAP2;
                else if (w_timeout) w_next = S_ERROR;
            end
            S_GAP2:  if (w_gapExpired) w_next = S_M1;
            S_M1: begin
                if (M1_done)        w_next = S_DONE;
                else if (w_timeout) w_next = S_ERROR;
            end
            S_DONE:  if (Start) w_next = S_LOAD;
            S_ERROR: w_next = S_ERROR;
            default: w_next = S_IDLE;
        endcase
    end

    // Counters restart on any state change so each stage and gap is timed from its own first cycle.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_state     <= S_IDLE;
            r_watchdog  <= 24'd0;
            r_gap       <= 3'd0;
            r_donePulse <= 1'b0;
        end else begin
            r_state     <= w_next;
            r_donePulse <= (w_next == S_DONE) && (r_state != S_DONE);
            if (w_next != r_state)
                r_watchdog <= 24'd0;
            else if (w_inStage)
                r_watchdog <= r_watchdog + 24'd1;
            if (w_next != r_state)
                r_gap <= 3'd0;
            else if (w_inGap)
                r_gap <= r_gap + 3'd1;
        end
    end

    // Outside an active stage the SRAM port is parked with writes disabled.
    always_comb begin
        LD_enable       = 1'b0;
        M2_enable       = 1'b0;
        M1_enable       = 1'b0;
        SRAM_address    = 18'd0;
        SRAM_write_data = 16'd0;
        SRAM_we_n       = 1'b1;
        Stage_id        = 2'd0;
        case (r_state)
            S_LOAD: begin
                LD_enable       = 1'b1;
                SRAM_address    = LD_SRAM_address;
                SRAM_write_data = LD_SRAM_write_data;
                SRAM_we_n       = LD_SRAM_we_n;
                Stage_id        = 2'd1;
            end
            S_M2: begin
                M2_enable       = 1'b1;
                SRAM_address    = M2_SRAM_address;
                SRAM_write_data = M2_SRAM_write_data;
                SRAM_we_n       = M2_SRAM_we_n;
                Stage_id        = 2'd2;
            end
            S_M1: begin
                M1_enable       = 1'b1;
                SRAM_address    = M1_SRAM_address;
                SRAM_write_data = M1_SRAM_write_data;
                SRAM_we_n       = M1_SRAM_we_n;
                Stage_id        = 2'd3;
            end
            default: ;
        endcase
    end

    assign Busy  = (r_state != S_IDLE) && (r_state != S_DONE) && (r_state != S_ERROR);
    assign Done  = r_donePulse && (r_state == S_DONE);
    assign Error = (r_state == S_ERROR);

endmodule

// File: tb/tb_milestone_sequencer.sv
// Directed bench for milestone_sequencer: three instances (nominal, short timeout, zero gap)
// share one stimulus set; each scenario checks the instance it was written for, cycle by cycle.
module tb_milestone_sequencer;

    logic        Clock = 1'b0;
    logic        Reset = 1'b1;
    logic        Start = 1'b0;
    logic        ldDone = 1'b0;
    logic        m2Done = 1'b0;
    logic        m1Done = 1'b0;
    logic [17:0] ldAddr = 18'h01234;
    logic [17:0] m2Addr = 18'h2ABCD;
    logic [17:0] m1Addr = 18'h3FFFF;
    logic [15:0] ldData = 16'h1111;
    logic [15:0] m2Data = 16'h2222;
    logic [15:0] m1Data = 16'h3333;
    logic        ldWeN = 1'b0;
    logic        m2WeN = 1'b1;
    logic        m1WeN = 1'b0;

    logic        aLdEn, aM2En, aM1En, aWeN, aBusy, aDone, aError;
    logic [17:0] aAddr;
    logic [15:0] aData;
    logic [1:0]  aStage;
    logic        bLdEn, bM2En, bM1En, bWeN, bBusy, bDone, bError;
    logic [17:0] bAddr;
    logic [15:0] bData;
    logic [1:0]  bStage;
    logic        zLdEn, zM2En, zM1En, zWeN, zBusy, zDone, zError;
    logic [17:0] zAddr;
    logic [15:0] zData;
    logic [1:0]  zStage;

    int vectors = 0;
    int miscompares = 0;

    always #5 Clock = ~Clock;

    milestone_sequencer #(.TIMEOUT_CYCLES(24'd64), .STAGE_GAP(3'd2)) dutA (
        .Clock(Clock), .Reset(Reset), .Start(Start),
        .LD_done(ldDone), .M2_done(m2Done), .M1_done(m1Done),
        .LD_SRAM_address(ldAddr), .M2_SRAM_address(m2Addr), .M1_SRAM_address(m1Addr),
        .LD_SRAM_write_data(ldData), .M2_SRAM_write_data(m2Data), .M1_SRAM_write_data(m1Data),
        .LD_SRAM_we_n(ldWeN), .M2_SRAM_we_n(m2WeN), .M1_SRAM_we_n(m1WeN),
        .LD_enable(aLdEn), .M2_enable(aM2En), .M1_enable(aM1En),
        .SRAM_address(aAddr), .SRAM_write_data(aData), .SRAM_we_n(aWeN),
        .Stage_id(aStage), .Busy(aBusy), .Done(aDone), .Error(aError)
    );

    milestone_sequencer #(.TIMEOUT_CYCLES(24'd16), .STAGE_GAP(3'd2)) dutB (
        .Clock(Clock), .Reset(Reset), .Start(Start),
        .LD_done(ldDone), .M2_done(m2Done), .M1_done(m1Done),
        .LD_SRAM_address(ldAddr), .M2_SRAM_address(m2Addr), .M1_SRAM_address(m1Addr),
        .LD_SRAM_write_data(ldData), .M2_SRAM_write_data(m2Data), .M1_SRAM_write_data(m1Data),
        .LD_SRAM_we_n(ldWeN), .M2_SRAM_we_n(m2WeN), .M1_SRAM_we_n(m1WeN),
        .LD_enable(bLdEn), .M2_enable(bM2En), .M1_enable(bM1En),
        .SRAM_address(bAddr), .SRAM_write_data(bData), .SRAM_we_n(bWeN),
        .Stage_id(bStage), .Busy(bBusy), .Done(bDone), .Error(bError)
    );

    milestone_sequencer #(.TIMEOUT_CYCLES(24'd64), .STAGE_GAP(3'd0)) dutZ (
        .Clock(Clock), .Reset(Reset), .Start(Start),
        .LD_done(ldDone), .M2_done(m2Done), .M1_done(m1Done),
        .LD_SRAM_address(ldAddr), .M2_SRAM_address(m2Addr), .M1_SRAM_address(m1Addr),
        .LD_SRAM_write_data(ldData), .M2_SRAM_write_data(m2Data), .M1_SRAM_write_data(m1Data),
        .LD_SRAM_we_n(ldWeN), .M2_SRAM_we_n(m2WeN), .M1_SRAM_we_n(m1WeN),
        .LD_enable(zLdEn), .M2_enable(zM2En), .M1_enable(zM1En),
        .SRAM_address(zAddr), .SRAM_write_data(zData), .SRAM_we_n(zWeN),
        .Stage_id(zStage), .Busy(zBusy), .Done(zDone), .Error(zError)
    );

    // Advance one clock and settle 2ns past the edge, where inputs are driven and outputs sampled.
    task automatic step();
        @(posedge Clock);
        #2;
    endtask

    // Expected SRAM bus {address, data, we_n} for a given one-hot stage enable.
    function automatic logic [34:0] expectedBus(input logic ld, input logic m2, input logic m1);
        if (ld) return {ldAddr, ldData, ldWeN};
        if (m2) return {m2Addr, m2Data, m2WeN};
        if (m1) return {m1Addr, m1Data, m1WeN};
        return {18'd0, 16'd0, 1'b1};
    endfunction

    // Reset all instances, then present Start for one cycle; afterwards the caller is in cycle 1.
    task automatic resetAndStart();
        Reset = 1'b1; Start = 1'b0; ldDone = 1'b0; m2Done = 1'b0; m1Done = 1'b0;
        step();
        Reset = 1'b0;
        Start = 1'b1;
        step();
        Start = 1'b0;
    endtask

    // Output values during reset and after release, before any Start.
    task automatic test_reset();
        logic [42:0] obs;
        Reset = 1'b1;
        step();
        step();
        #1;
        obs = {aLdEn, aM2En, aM1En, aStage, aBusy, aDone, aError, aAddr, aData, aWeN};
        vectors++;
        if (obs !== {8'b0, 18'd0, 16'd0, 1'b1}) begin
            miscompares++;
            $display("[TB] FAIL reset.during got=%h want=%h", obs, {8'b0, 18'd0, 16'd0, 1'b1});
        end
        Reset = 1'b0;
        step();
        step();
        #1;
        obs = {bLdEn, bM2En, bM1En, bStage, bBusy, bDone, bError, bAddr, bData, bWeN};
        vectors++;
        if (obs !== {8'b0, 18'd0, 16'd0, 1'b1}) begin
            miscompares++;
            $display("[TB] FAIL reset.after got=%h want=%h", obs, {8'b0, 18'd0, 16'd0, 1'b1});
        end
    endtask

    // Full run on the 64-cycle-timeout instance: LOAD 1-10, GAP1 11-12, M2 13-33, GAP2 34-35,
    // M1 36-51, DONE from 52. M1 parks 0x3FFFF/we_n=0 on its inputs the whole time to prove isolation.
    task automatic test_nominal();
        logic [7:0]  obsCtl, expCtl;
        logic [34:0] obsBus, expBus;
        logic        eLd, eM2, eM1;
        logic [1:0]  eStage;
        int          donePulses = 0;
        resetAndStart();
        for (int c = 1; c <= 56; c++) begin
            ldDone = (c == 10);
            m2Done = (c == 33);
            m1Done = (c == 51);
            #1;
            eLd = (c >= 1 && c <= 10);
            eM2 = (c >= 13 && c <= 33);
            eM1 = (c >= 36 && c <= 51);
            eStage = eLd ? 2'd1 : eM2 ? 2'd2 : eM1 ? 2'd3 : 2'd0;
            expCtl = {eLd, eM2, eM1, eStage, (c <= 51), (c == 52), 1'b0};
            obsCtl = {aLdEn, aM2En, aM1En, aStage, aBusy, aDone, aError};
            vectors++;
            if (obsCtl !== expCtl) begin
                miscompares++;
                $display("[TB] FAIL nominal.ctl cyc=%0d got=%b want=%b", c, obsCtl, expCtl);
            end
            expBus = expectedBus(eLd, eM2, eM1);
            obsBus = {aAddr, aData, aWeN};
            vectors++;
            if (obsBus !== expBus) begin
                miscompares++;
                $display("[TB] FAIL nominal.mux cyc=%0d got=%h want=%h", c, obsBus, expBus);
            end
            if (aDone === 1'b1) donePulses++;
            step();
        end
        ldDone = 1'b0; m2Done = 1'b0; m1Done = 1'b0;
        vectors++;
        if (donePulses !== 1) begin
            miscompares++;
            $display("[TB] FAIL nominal.donecount got=%0d want=1", donePulses);
        end
    endtask

    // 16-cycle timeout, M2_done never comes: M2 runs cycles 6-21, Error from cycle 22; Start at 22 ignored.
    task automatic test_timeout();
        logic [6:0] obsCtl, expCtl;
        resetAndStart();
        for (int c = 1; c <= 25; c++) begin
            ldDone = (c == 3);
            Start  = (c == 22);
            #1;
            expCtl = {(c <= 3), (c >= 6 && c <= 21), 1'b0,
                      (c <= 3) ? 2'd1 : (c >= 6 && c <= 21) ? 2'd2 : 2'd0,
                      (c <= 21), (c >= 22)};
            obsCtl = {bLdEn, bM2En, bM1En, bStage, bBusy, bError};
            vectors++;
            if (obsCtl !== expCtl) begin
                miscompares++;
                $display("[TB] FAIL timeout.ctl cyc=%0d got=%b want=%b", c, obsCtl, expCtl);
            end
            step();
        end
        ldDone = 1'b0; Start = 1'b0;
    endtask

    // Foreign done pulses are ignored; M2_done on the exact timeout cycle (22) still reaches GAP2.
    // LOAD 1-4, GAP1 5-6, M2 7-22, GAP2 23-24, M1 25-27.
    task automatic test_spurious();
        logic [6:0] obsCtl, expCtl;
        logic       eLd, eM2, eM1;
        resetAndStart();
        for (int c = 1; c <= 27; c++) begin
            m1Done = (c == 2) || (c == 23);
            m2Done = (c == 3) || (c == 22);
            ldDone = (c == 4) || (c == 10);
            #1;
            eLd = (c <= 4);
            eM2 = (c >= 7 && c <= 22);
            eM1 = (c >= 25);
            expCtl = {eLd, eM2, eM1, eLd ? 2'd1 : eM2 ? 2'd2 : eM1 ? 2'd3 : 2'd0, 1'b1, 1'b0};
            obsCtl = {bLdEn, bM2En, bM1En, bStage, bBusy, bError};
            vectors++;
            if (obsCtl !== expCtl) begin
                miscompares++;
                $display("[TB] FAIL spurious.ctl cyc=%0d got=%b want=%b", c, obsCtl, expCtl);
            end
            step();
        end
        ldDone = 1'b0; m2Done = 1'b0; m1Done = 1'b0;
    endtask

    // Start during LOAD (5) and GAP1 (8) is ignored; Start in the first DONE cycle (13) restarts at 14.
    // LOAD 1-6, GAP1 7-8, M2 9, GAP2 10-11, M1 12, DONE 13, LOAD 14-15.
    task automatic test_back_to_back();
        logic [7:0] obsCtl, expCtl;
        logic       eLd, eM2, eM1;
        resetAndStart();
        for (int c = 1; c <= 15; c++) begin
            Start  = (c == 5) || (c == 8) || (c == 13);
            ldDone = (c == 6);
            m2Done = (c == 9);
            m1Done = (c == 12);
            #1;
            eLd = (c <= 6) || (c >= 14);
            eM2 = (c == 9);
            eM1 = (c == 12);
            expCtl = {eLd, eM2, eM1, eLd ? 2'd1 : eM2 ? 2'd2 : eM1 ? 2'd3 : 2'd0,
                      (c != 13), (c == 13), 1'b0};
            obsCtl = {aLdEn, aM2En, aM1En, aStage, aBusy, aDone, aError};
            vectors++;
            if (obsCtl !== expCtl) begin
                miscompares++;
                $display("[TB] FAIL start.ctl cyc=%0d got=%b want=%b", c, obsCtl, expCtl);
            end
            step();
        end
        Start = 1'b0; ldDone = 1'b0; m2Done = 1'b0; m1Done = 1'b0;
    endtask

    // Reset raised in M1 (cycle 8) gives idle outputs at 9, then a fresh Start at 10 runs through:
    // LOAD 1, M2 4, M1 7-8, IDLE 9-10, LOAD 11, M2 14, M1 17, DONE 18-19.
    task automatic test_reset_midstage();
        logic [7:0]  obsCtl, expCtl;
        logic [34:0] obsBus, expBus;
        logic        eLd, eM2, eM1;
        resetAndStart();
        for (int c = 1; c <= 19; c++) begin
            Reset  = (c == 8);
            Start  = (c == 10);
            ldDone = (c == 1) || (c == 11);
            m2Done = (c == 4) || (c == 14);
            m1Done = (c == 17);
            #1;
            eLd = (c == 1) || (c == 11);
            eM2 = (c == 4) || (c == 14);
            eM1 = (c == 7) || (c == 8) || (c == 17);
            expCtl = {eLd, eM2, eM1, eLd ? 2'd1 : eM2 ? 2'd2 : eM1 ? 2'd3 : 2'd0,
                      (c <= 8) || (c >= 11 && c <= 17), (c == 18), 1'b0};
            obsCtl = {aLdEn, aM2En, aM1En, aStage, aBusy, aDone, aError};
            vectors++;
            if (obsCtl !== expCtl) begin
                miscompares++;
                $display("[TB] FAIL midreset.ctl cyc=%0d got=%b want=%b", c, obsCtl, expCtl);
            end
            expBus = expectedBus(eLd, eM2, eM1);
            obsBus = {aAddr, aData, aWeN};
            vectors++;
            if (obsBus !== expBus) begin
                miscompares++;
                $display("[TB] FAIL midreset.mux cyc=%0d got=%h want=%h", c, obsBus, expBus);
            end
            step();
        end
        Reset = 1'b0; Start = 1'b0; ldDone = 1'b0; m2Done = 1'b0; m1Done = 1'b0;
    endtask

    // Zero-gap instance: each done pulse moves straight to the next stage. LOAD 1, M2 2, M1 3, DONE 4-5.
    task automatic test_zero_gap();
        logic [7:0] obsCtl, expCtl;
        resetAndStart();
        for (int c = 1; c <= 5; c++) begin
            ldDone = (c == 1);
            m2Done = (c == 2);
            m1Done = (c == 3);
            #1;
            expCtl = {(c == 1), (c == 2), (c == 3),
                      (c <= 3) ? c[1:0] : 2'd0, (c <= 3), (c == 4), 1'b0};
            obsCtl = {zLdEn, zM2En, zM1En, zStage, zBusy, zDone, zError};
            vectors++;
            if (obsCtl !== expCtl) begin
                miscompares++;
                $display("[TB] FAIL zerogap.ctl cyc=%0d got=%b want=%b", c, obsCtl, expCtl);
            end
            step();
        end
        ldDone = 1'b0; m2Done = 1'b0; m1Done = 1'b0;
    endtask

    // Scenario order matters only in that every scenario begins with its own reset.
    initial begin
        test_reset();
        test_nominal();
        test_timeout();
        test_spurious();
        test_back_to_back();
        test_reset_midstage();
        test_zero_gap();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
